shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Sequencing controller for the team's 4-bit universal shift/load register. On a `start` request it drives the register's `shift`/`load` select lines and `serial` input to perform a parallel load, an N-bit serial shift-in, a load-then-shift transfer, or an N-bit rotate. While shifting it collects the bits leaving the register MSB into a 4-bit result word. It sits between a host that issues transfer commands and one register instance; the register's parallel input `I` is wired by the host, not by this block.

## Interface
- `SEL_HOLD`, default 2'b00: {shift,load} code that holds register contents.
- `SEL_LOAD`, default 2'b10: {shift,load} code that parallel-loads `I`.
- `SEL_SHIFT`, default 2'b11: {shift,load} code that shifts toward MSB (A[0] <= serial).
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command request; sampled only in IDLE.
- `mode` in 2: 00 load only, 01 shift, 10 load then shift, 11 rotate; captured with `start`.
- `count` in 3: number of shift cycles, 1–4; 0 means 4; values 5–7 saturate to 4; captured with `start`.
- `sdata` in 4: serial source word, sent LSB first; captured with `start`.
- `a_msb` in 1: register bit A[3], fed back from the register.
- `shift`, `load` out 1 each: register select, driven as {shift,load} = one of the SEL_* codes.
- `serial` out 1: register serial input.
- `busy` out 1: high in LOAD and SHIFT.
- `done` out 1: one-cycle completion pulse.
- `out_word` out 4: bits shifted out of A[3], MSB-first accumulation.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Moore outputs decode from state.
- IDLE: {shift,load}=SEL_HOLD; `serial`=0. On `start`=1:
  - capture `mode`, the effective count n, and `sdata` into `sbuf`;
  - clear `out_word`;
  - go to LOAD for modes 00/10, or SHIFT for modes 01/11.
- LOAD: one cycle with SEL_LOAD. Mode 00 goes to DONE. Mode 10 goes to SHIFT.
- SHIFT: SEL_SHIFT for exactly n cycles. Each cycle:
  - `serial` = `sbuf[0]` (modes 01/10) or `a_msb` (mode 11);
  - at the edge, `out_word` <= {out_word[2:0], a_msb}, `sbuf` >>= 1, remaining count decrements.
  - Go to DONE after the n-th shift edge.
- DONE: SEL_HOLD, `done`=1 for one cycle, `busy`=0; then IDLE unconditionally.
- `start` in LOAD, SHIFT or DONE is ignored; it is not queued. Held `start` re-triggers from IDLE, so there is at least one IDLE cycle between commands.
- `out_word` holds its value from DONE until the next accepted `start`.

## Timing
- Reset: state IDLE, `shift`=`load`=0 (SEL_HOLD), `serial`=0, `busy`=0, `done`=0, `out_word`=0, `sbuf`=0, counter=0.
- `rst` mid-operation: IDLE with SEL_HOLD from the next cycle; no `done` pulse. Register contents are left as partially updated, because the controller never resets the register.
- `rst` has priority over `start` in the same cycle.
- With `start` sampled at edge 0, the first command cycle is cycle 1.
  - Mode 00: LOAD in cycle 1, `done` in cycle 2.
  - Mode 01/11: SHIFT in cycles 1..n, `done` in cycle n+1.
  - Mode 10: LOAD in cycle 1, SHIFT in cycles 2..n+1, `done` in cycle n+2.
- Rotate uses the pre-edge `a_msb` each cycle. This is combinational from the register, with no added latency.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1. Required: all outputs 0, state IDLE, no `done`.
- Mode 10, count 4, I=1011, sdata=0110. Required: `done` in cycle 6, register A=0110, `out_word`=1011, `busy` high in cycles 1–5.
- Mode 11, count 1, A=1011. Required: A=0111, `out_word`=0001, `done` in cycle 2.
- Mode 00 with I=1011, then mode 01 with count=0 and sdata=0000. Required: the second command shifts 4 times, giving A=0000 and `out_word`=1011.
- Mode 01, count 4, `rst` asserted after 2 shift edges. Required: SEL_HOLD the next cycle, `busy`=0, no `done`, A keeps its 2-shift value.
- `start` pulsed in SHIFT and in DONE. Required: ignored, and `mode`, `count` and `out_word` are unchanged. A held `start` restarts only after one IDLE cycle.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencing controller for a 4-bit universal shift/load register
module shift_seq_ctrl #(
  parameter logic [1:0] SEL_HOLD  = 2'b00,
  parameter logic [1:0] SEL_LOAD  = 2'b10,
  parameter logic [1:0] SEL_SHIFT = 2'b11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_mode,
  input  logic [2:0] i_count,
  input  logic [3:0] i_sdata,
  input  logic       i_a_msb,
  output logic       o_shift,
  output logic       o_load,
  output logic       o_serial,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_out_word
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LOAD       = 2'b00;
  localparam logic [1:0] MODE_SHIFT      = 2'b01;
  localparam logic [1:0] MODE_LOAD_SHIFT = 2'b10;
  localparam logic [1:0] MODE_ROTATE     = 2'b11;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_mode;
  logic [2:0] r_cnt;
  logic [3:0] r_sbuf;
  logic [3:0] r_out_word;
  logic [2:0] w_eff_cnt;
  logic [1:0] w_sel;
  logic       w_serial;
  logic       w_busy;
  logic       w_done;
  logic       w_accept;

  // A zero count means a full word; anything above four is clamped to a full word.
  assign w_eff_cnt = ((i_count == 3'd0) || (i_count > 3'd4)) ? 3'd4 : i_count;

  // Commands are only taken while idle; start elsewhere is dropped, not queued.
  assign w_accept = (r_state == S_IDLE) && i_start;

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode; serial follows a_msb combinationally while rotating.
  always_comb begin
    w_next_state = r_state;
    w_sel        = SEL_HOLD;
    w_serial     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if ((i_mode == MODE_LOAD) || (i_mode == MODE_LOAD_SHIFT)) begin
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_SHIFT;
          end
        end
      end
      S_LOAD: begin
        w_sel  = SEL_LOAD;
        w_busy = 1'b1;
        if (r_mode == MODE_LOAD_SHIFT) begin
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_SHIFT: begin
        w_sel  = SEL_SHIFT;
        w_busy = 1'b1;
        if (r_mode == MODE_ROTATE) begin
          w_serial = i_a_msb;
        end else begin
          w_serial = r_sbuf[0];
        end
        if (r_cnt <= 3'd1) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Command capture on accept, then per-shift bookkeeping of source bits, count and result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode     <= MODE_LOAD;
      r_cnt      <= 3'd0;
      r_sbuf     <= 4'd0;
      r_out_word <= 4'd0;
    end else if (w_accept) begin
      r_mode     <= i_mode;
      r_cnt      <= w_eff_cnt;
      r_sbuf     <= i_sdata;
      r_out_word <= 4'd0;
    end else if (r_state == S_SHIFT) begin
      r_out_word <= {r_out_word[2:0], i_a_msb};
      r_sbuf     <= {1'b0, r_sbuf[3:1]};
      r_cnt      <= r_cnt - 3'd1;
    end
  end

  assign o_shift    = w_sel[1];
  assign o_load     = w_sel[0];
  assign o_serial   = w_serial;
  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_out_word = r_out_word;

  // MODE_SHIFT is named for readability of the decode; it has no dedicated branch.
  logic w_unused_mode;
  assign w_unused_mode = (r_mode == MODE_SHIFT);

endmodule
